uart_tx_param: RTL and testbench

Parametrised UART transmitter: serialises one parallel word per valid/ready handshake onto `TxD` with start bit, LSB-first data, optional parity and one or two stop bits. Baud timing is derived from the system clock by a programmable divider. The block is the next-generation transmit path for the serial link. Explicit handshaking replaces data-change detection, and back-to-back frames can be sent with no idle gap.

---
 rtl/uart_tx_param.sv | 80 ++++++++
 tb/tb_uart_tx_param.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with valid/ready input and registered TxD
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   tx_data  : word to send, sampled on handshake
//   tx_valid : tx_data is valid
//   tx_ready : word accepted this cycle (IDLE, or last cycle of last stop bit)
//   TxD      : serial line, idle high
//   busy     : a frame is in progress
module uart_tx_param #(
    parameter int CLK_DIV   = 5208,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 TxD,
    output logic                 busy
);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               r_state, w_next;
    logic [BW-1:0]        r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par, r_txd;
    logic                 w_tick, w_data_last, w_stop_last, w_accept;

    assign w_tick      = r_baud == BAUD_LAST;
    assign w_data_last = w_tick && r_bit == 4'(DATA_BITS - 1);
    assign w_stop_last = w_tick && r_bit == 4'(STOP_BITS - 1);
    assign tx_ready    = r_state == S_IDLE || (r_state == S_STOP && w_stop_last);
    assign w_accept    = tx_valid && tx_ready;
    assign busy        = r_state != S_IDLE;
    assign TxD         = r_txd;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_START;
            S_START: if (w_tick) w_next = S_DATA;
            S_DATA:  if (w_data_last) w_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (w_tick) w_next = S_STOP;
            S_STOP:  if (w_stop_last) w_next = w_accept ? S_START : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // TxD is driven from the current state, so the line lags the state by one
    // cycle: a handshake at edge N shows the start bit from edge N+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_next;
            r_baud  <= (r_state == S_IDLE || w_tick) ? '0 : r_baud + 1'b1;
            r_bit   <= (w_next != r_state) ? '0 : w_tick ? r_bit + 1'b1 : r_bit;
            if (w_accept) begin
                r_shift <= tx_data;
                r_par   <= ^tx_data ^ (PARITY == 1);
            end else if (r_state == S_DATA && w_tick) begin
                r_shift <= r_shift >> 1;
            end
            r_txd <= r_state == S_START ? 1'b0 :
                     r_state == S_DATA  ? r_shift[0] :
                     r_state == S_PAR   ? r_par : 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: frame-level model check of uart_tx_param in four configurations
module tb_uart_tx_param;
    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] valid, ready, txd, busy;
    logic [8:0] data [4];
    int         tests = 0, fails = 0;

    // Expected TxD per cycle; an accepted word becomes a list of bit samples.
    logic       q [4][$];
    logic       st1 [4], st2 [4];
    logic [8:0] w1 [4], w2 [4];

    always #5 clk = ~clk;

    // instance 0: 8N1, 1: 8E1, 2: 8O1, 3: 7N2
    function automatic int db(int i); return i == 3 ? 7 : 8; endfunction
    function automatic int par(int i); return i == 1 ? 2 : i == 2 ? 1 : 0; endfunction
    function automatic int sb(int i); return i == 3 ? 2 : 1; endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DB = (g == 3) ? 7 : 8;
        localparam int PB = (g == 1) ? 2 : (g == 2) ? 1 : 0;
        localparam int SB = (g == 3) ? 2 : 1;
        uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(DB), .PARITY(PB), .STOP_BITS(SB)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .tx_data  (data[g][DB-1:0]),
            .tx_valid (valid[g]),
            .tx_ready (ready[g]),
            .TxD      (txd[g]),
            .busy     (busy[g])
        );
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_frame(int i, logic [8:0] w);
        logic bits [$];
        logic p = 1'b0;
        bits.push_back(1'b0);
        for (int k = 0; k < db(i); k++) begin
            bits.push_back(w[k]);
            p ^= w[k];
        end
        if (par(i) != 0) bits.push_back(par(i) == 2 ? p : ~p);
        for (int k = 0; k < sb(i); k++) bits.push_back(1'b1);
        foreach (bits[k]) repeat (CD) q[i].push_back(bits[k]);
    endtask

    // A word accepted at edge N is decided at the negedge before N (st1),
    // is in flight while TxD still shows the old value (st2), and its samples
    // start one negedge later.
    always @(negedge clk) begin
        logic e, er, eb;
        for (int i = 0; i < 4; i++) begin
            if (!reset) begin
                q[i].delete();
                st1[i] = 1'b0;
                st2[i] = 1'b0;
            end
            if (st2[i]) begin
                push_frame(i, w2[i]);
                st2[i] = 1'b0;
            end
            if (st1[i]) begin
                st2[i] = 1'b1;
                w2[i]  = w1[i];
                st1[i] = 1'b0;
            end
            e  = q[i].size() > 0 ? q[i].pop_front() : 1'b1;
            eb = st2[i] || q[i].size() > 0;
            er = !st2[i] && q[i].size() <= 1;
            chk($sformatf("txd%0d", i), txd[i], e);
            chk($sformatf("busy%0d", i), busy[i], eb);
            chk($sformatf("ready%0d", i), ready[i], er);
            if (reset && valid[i] && er) begin
                st1[i] = 1'b1;
                w1[i]  = data[i];
            end
        end
    end

    task automatic send(int i, logic [8:0] w);
        int n = 0;
        @(posedge clk); #1;
        data[i]  = w;
        valid[i] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ready[i] && n < 200);
        chk($sformatf("accept%0d", i), ready[i], 1);
        @(posedge clk); #1;
        valid[i] = 1'b0;
    endtask

    // Samples the middle of each bit; first bit ends up in the MSB.
    task automatic capture(int i, int n, output logic [11:0] v);
        v = '0;
        repeat (3) @(negedge clk);
        v = {v[10:0], txd[i]};
        for (int k = 1; k < n; k++) begin
            repeat (4) @(negedge clk);
            v = {v[10:0], txd[i]};
        end
    endtask

    initial begin
        logic [11:0] v;
        int nb, cnt, first;
        reset = 1'b0;
        valid = '0;
        for (int i = 0; i < 4; i++) data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd, 4'hF);
        chk("rst_ready", ready, 4'hF);
        chk("rst_busy", busy, 4'h0);
        reset = 1'b1;

        send(0, 9'hA5);
        capture(0, 10, v);
        chk("frame_a5", v[9:0], 10'b0101001011);
        repeat (10) @(negedge clk);

        send(0, 9'h5A);
        @(negedge clk);
        chk("lat_idle", txd[0], 1);
        nb = busy[0];
        @(negedge clk);
        chk("lat_start", txd[0], 0);
        nb += busy[0];
        repeat (48) begin
            @(negedge clk);
            nb += busy[0];
        end
        chk("busy_cycles", nb, 40);

        send(1, 9'h07);
        capture(1, 11, v);
        chk("even_frame", v[10:0], 11'b01110000011);
        repeat (10) @(negedge clk);
        send(2, 9'h07);
        capture(2, 11, v);
        chk("odd_frame", v[10:0], 11'b01110000001);
        repeat (10) @(negedge clk);
        send(3, 9'h7F);
        capture(3, 10, v);
        chk("two_stop_frame", v[9:0], 10'b0111111111);
        repeat (10) @(negedge clk);

        @(posedge clk); #1;
        data[0]  = 9'h55;
        valid[0] = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!ready[0] && cnt < 200);
        chk("b2b_accept", ready[0], 1);
        @(posedge clk); #1;
        data[0] = 9'hAA;
        cnt     = 0;
        first   = -1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (ready[0]) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        @(posedge clk); #1;
        valid[0] = 1'b0;
        chk("b2b_ready_pulses", cnt, 2);
        chk("b2b_ready_index", first, 39);
        repeat (60) @(negedge clk);

        send(0, 9'hF0);
        repeat (18) @(negedge clk);
        chk("mid_data3", txd[0], 0);
        #3 reset = 1'b0;
        #1;
        chk("async_txd", txd, 4'hF);
        chk("async_ready", ready, 4'hF);
        chk("async_busy", busy, 4'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (5) @(negedge clk);

        send(0, 9'h3C);
        data[0] = 9'h0F;
        fork
            capture(0, 10, v);
            begin
                repeat (13) @(posedge clk);
                #1 data[0] = 9'h81;
            end
        join
        chk("frame_3c", v[9:0], 10'b0001111001);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end
endmodule
